dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port, synchronous-read data memory (DMEM) between the RV32I
//  MEM stage (core) and a host loader/debug port, which preloads and inspects DMEM.
//  Sits between MEM stage and DMEM macro. Stalls the core when the host wins.
//  Raises a sticky halt when the halt word is written to the last DMEM location.
// PARAMETERS
//  ADDR_W      8             DMEM word-address width (depth = 2**ADDR_W)
//  MAX_WAIT    4             consecutive host-denied cycles before host is forced in
//  HALT_MAGIC  32'h0000FE23  data word that signals program end
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       reset, ASYNCHRONOUS, ACTIVE-HIGH (asserted = 1)
//  core_req     in   1       core access request (MEM stage load/store)
//  core_we      in   1       1 = store, 0 = load
//  core_addr    in   ADDR_W  core word address
//  core_wdata   in   32      store data
//  core_be      in   4       store byte enables
//  core_gnt     out  1       core request accepted this cycle
//  core_stall   out  1       core_req & ~core_gnt; freezes pipeline
//  core_rvalid  out  1       core load data valid (1 cycle after load grant)
//  core_rdata   out  32      core load data
//  host_req     in   1       host access request
//  host_we      in   1       1 = write, 0 = read
//  host_addr    in   ADDR_W  host word address
//  host_wdata   in   32      host write data
//  host_be      in   4       host byte enables
//  host_gnt     out  1       host request accepted this cycle
//  host_rvalid  out  1       host read data valid (1 cycle after read grant)
//  host_rdata   out  32      host read data
//  mem_en       out  1       DMEM enable
//  mem_we       out  4       DMEM byte write enables (0 on reads)
//  mem_addr     out  ADDR_W  DMEM address
//  mem_wdata    out  32      DMEM write data
//  mem_rdata    in   32      DMEM read data, valid cycle after mem_en & ~|mem_we
//  halt         out  1       sticky program-end flag
// BEHAVIOUR
//  - Reset: wait_cnt=0, rd_owner=NONE, halt=0, core_rvalid=host_rvalid=0; grants are
//    combinational and follow the rules below from the first cycle after reset.
//  - Grant (combinational, same cycle as req), at most one grant per cycle:
//    host_force = (wait_cnt == MAX_WAIT) & host_req.
//    host_gnt   = host_req & (host_force | ~core_req | halt).
//    core_gnt   = core_req & ~host_gnt & ~halt.
//  - wait_cnt: +1 when host_req & ~host_gnt (saturates at MAX_WAIT); 0 when host_gnt
//    or ~host_req. Bounds host wait to MAX_WAIT cycles; each forced cycle stalls core 1.
//  - Mem drive: mem_en = core_gnt|host_gnt; addr/wdata/be from granted side;
//    mem_we = be when granted side writes, else 4'b0. No grant -> mem_en=0, mem_we=0.
//  - Read return FSM, rd_owner in {NONE,CORE,HOST}, registered each cycle:
//    load granted -> owner of that grant; otherwise NONE. Latency exactly 1 cycle.
//    core_rvalid = (rd_owner==CORE); host_rvalid = (rd_owner==HOST);
//    both rdata outputs = mem_rdata (qualified by rvalid). Back-to-back reads OK.
//  - Halt: set on a granted core write with addr == 2**ADDR_W-1, be == 4'hF,
//    wdata == HALT_MAGIC. Host writes never set halt. Cleared only by reset.
//    Once set: core_gnt=0, core_stall=core_req; host retains full access.
//  - Halting write itself completes (written to DMEM) in the cycle it is granted.
//  - Partial-BE write of HALT_MAGIC to last address: written, halt not set.
//  - Reset mid-operation: outstanding read return discarded (rvalid=0 next cycle),
//    wait_cnt and halt cleared; no DMEM write occurs while reset is asserted.
// TESTING
//  1 Core-only loads/stores addr 0..15: core_gnt=1 each cycle, stall=0, rdata=written
//    value 1 cycle after load.
//  2 core_req held high, host read addr 5 held: host denied 4 cycles, granted 5th;
//    core_stall=1 exactly that cycle; host_rvalid next cycle with DMEM[5].
//  3 Core store 32'h0000FE23, be=F, addr 255 -> halt=1 next cycle, DMEM[255]=FE23;
//    later core_req -> core_stall=1; host read addr 255 -> 32'h0000FE23.
//  4 Host write FE23 to addr 255 -> halt stays 0; core store FE23 be=4'h3 -> halt 0.
//  5 Alternating core load / host load every cycle: rvalid routed to correct side,
//    never both high, data matches address.
//  6 Assert rst_n (=1) one cycle after a core load grant -> core_rvalid stays 0,
//    halt=0, wait_cnt=0; accesses resume after release.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
//   Bundles the three buses around the DMEM arbiter: the core (MEM stage)
//   request port, the host loader/debug port, and the DMEM macro port, plus
//   the sticky halt flag.
//   modport master : the environment side (core, host, DMEM macro)
//   modport slave  : the arbiter side
// Signals
//   core_req/we/addr/wdata/be   core request        core_gnt/stall/rvalid/rdata
//   host_req/we/addr/wdata/be   host request        host_gnt/rvalid/rdata
//   mem_en/we/addr/wdata        DMEM drive          mem_rdata (sync read, +1 cycle)
//   halt                        sticky program-end flag
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [31:0]       core_wdata;
    logic [3:0]        core_be;
    logic              core_gnt;
    logic              core_stall;
    logic              core_rvalid;
    logic [31:0]       core_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [31:0]       host_wdata;
    logic [3:0]        host_be;
    logic              host_gnt;
    logic              host_rvalid;
    logic [31:0]       host_rdata;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              halt;

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_be,
        input  core_gnt, core_stall, core_rvalid, core_rdata,
        output host_req, host_we, host_addr, host_wdata, host_be,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  halt
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_be,
        output core_gnt, core_stall, core_rvalid, core_rdata,
        input  host_req, host_we, host_addr, host_wdata, host_be,
        output host_gnt, host_rvalid, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output halt
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares a single-port, synchronous-read DMEM between the RV32I MEM stage
//   (core) and a host loader/debug port. The core normally wins; a host that
//   has been denied MAX_WAIT consecutive cycles is forced in for one cycle,
//   stalling the core. A full-word core store of HALT_MAGIC to the last DMEM
//   word raises a sticky halt, after which only the host is served.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous reset, ACTIVE-HIGH despite the name (1 = in reset)
//   bus    dmem_port_arbiter_if.slave: core, host and DMEM buses plus halt
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int          ADDR_W     = 8,
    parameter int          MAX_WAIT   = 4,
    parameter logic [31:0] HALT_MAGIC = 32'h0000FE23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_port_arbiter_if.slave   bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        RD_NONE,
        RD_CORE,
        RD_HOST
    } rd_owner_t;

    rd_owner_t         rd_owner;
    logic [WAIT_W-1:0] wait_cnt;
    logic              halt_q;
    logic              host_force;
    logic              host_gnt;
    logic              core_gnt;
    logic              halt_hit;

    // Grants are combinational. Both are suppressed while reset is held so
    // that no DMEM write can slip through during reset.
    assign host_force = (wait_cnt == WAIT_MAX) && bus.host_req;
    assign host_gnt   = bus.host_req && (host_force || !bus.core_req || halt_q) && !rst_n;
    assign core_gnt   = bus.core_req && !host_gnt && !halt_q && !rst_n;

    assign halt_hit = core_gnt && bus.core_we
                   && (bus.core_addr == {ADDR_W{1'b1}})
                   && (bus.core_be == 4'hF)
                   && (bus.core_wdata == HALT_MAGIC);

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (host_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.host_we ? bus.host_be : 4'b0000;
            bus.mem_addr  = bus.host_addr;
            bus.mem_wdata = bus.host_wdata;
        end else if (core_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.core_we ? bus.core_be : 4'b0000;
            bus.mem_addr  = bus.core_addr;
            bus.mem_wdata = bus.core_wdata;
        end
    end

    // Read-return tracking, host wait counter and sticky halt.
    // NOTE: non-blocking assignments make every register update from the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_owner <= RD_NONE;
            wait_cnt <= '0;
            halt_q   <= 1'b0;
        end else begin
            if (core_gnt && !bus.core_we)
                rd_owner <= RD_CORE;
            else if (host_gnt && !bus.host_we)
                rd_owner <= RD_HOST;
            else
                rd_owner <= RD_NONE;

            if (bus.host_req && !host_gnt) begin
                if (wait_cnt != WAIT_MAX)
                    wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (halt_hit)
                halt_q <= 1'b1;
        end
    end

    assign bus.core_gnt    = core_gnt;
    assign bus.host_gnt    = host_gnt;
    assign bus.core_stall  = bus.core_req && !core_gnt;
    assign bus.core_rvalid = (rd_owner == RD_CORE);
    assign bus.host_rvalid = (rd_owner == RD_HOST);
    // Single read path from the macro; each side qualifies it with its rvalid.
    assign bus.core_rdata  = bus.mem_rdata;
    assign bus.host_rdata  = bus.mem_rdata;
    assign bus.halt        = halt_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Directed bench for dmem_port_arbiter. Models the DMEM macro as a
//   byte-writable, synchronous-read array. Inputs change just after the
//   falling edge; grant/mem outputs are sampled 1 time unit later, and
//   registered read-return outputs 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
    localparam int ADDR_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .MAX_WAIT  (4),
        .HALT_MAGIC(32'h0000FE23)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // DMEM macro model: byte writes, registered read data.
    logic [31:0] dmem [0:(1<<ADDR_W)-1];
    logic [31:0] rd_q;
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) dmem[i] = 32'h0;
        rd_q = 32'h0;
    end
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (|bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_we[b]) dmem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                rd_q <= dmem[bus.mem_addr];
            end
        end
    end
    assign bus.mem_rdata = rd_q;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic core_drive(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
        bus.core_req = req; bus.core_we = we; bus.core_addr = addr;
        bus.core_wdata = wdata; bus.core_be = be;
    endtask

    task automatic host_drive(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
        bus.host_req = req; bus.host_we = we; bus.host_addr = addr;
        bus.host_wdata = wdata; bus.host_be = be;
    endtask

    task automatic idle();
        core_drive(1'b0, 1'b0, '0, 32'h0, 4'h0);
        host_drive(1'b0, 1'b0, '0, 32'h0, 4'h0);
    endtask

    // From just after a falling edge, move to 1 unit after the next rising edge.
    task automatic to_post_rise();
        @(posedge clk); #1;
    endtask

    initial begin
        idle();

        // ---- Reset state; a core store held during reset must not reach DMEM.
        core_drive(1'b1, 1'b1, 8'd200, 32'hDEADBEEF, 4'hF);
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_core_gnt", 32'(bus.core_gnt), 32'd0);
        check("rst_core_rvalid", 32'(bus.core_rvalid), 32'd0);
        check("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
        check("rst_halt", 32'(bus.halt), 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_no_write", dmem[200], 32'h0);

        // ---- 1: core-only stores then loads, addresses 0..15.
        for (int i = 0; i < 16; i++) begin
            core_drive(1'b1, 1'b1, ADDR_W'(i), 32'hA5000000 + i, 4'hF);
            #1;
            check($sformatf("t1_st_gnt%0d", i), 32'(bus.core_gnt), 32'd1);
            check($sformatf("t1_st_stall%0d", i), 32'(bus.core_stall), 32'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 16; i++) begin
            core_drive(1'b1, 1'b0, ADDR_W'(i), 32'h0, 4'h0);
            #1;
            check($sformatf("t1_ld_gnt%0d", i), 32'(bus.core_gnt), 32'd1);
            check($sformatf("t1_ld_memwe%0d", i), 32'(bus.mem_we), 32'd0);
            to_post_rise();
            check($sformatf("t1_rvalid%0d", i), 32'(bus.core_rvalid), 32'd1);
            check($sformatf("t1_rdata%0d", i), bus.core_rdata, 32'hA5000000 + i);
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        check("t1_rvalid_drop", 32'(bus.core_rvalid), 32'd0);

        // ---- 2: host read of addr 5 against a continuously requesting core.
        core_drive(1'b1, 1'b0, 8'd0, 32'h0, 4'h0);
        host_drive(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t2_host_gnt%0d", k), 32'(bus.host_gnt), (k == 4) ? 32'd1 : 32'd0);
            check($sformatf("t2_stall%0d", k), 32'(bus.core_stall), (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) check("t2_mem_addr", 32'(bus.mem_addr), 32'd5);
            to_post_rise();
            if (k == 4) begin
                check("t2_host_rvalid", 32'(bus.host_rvalid), 32'd1);
                check("t2_host_rdata", bus.host_rdata, 32'hA5000005);
                check("t2_core_rvalid", 32'(bus.core_rvalid), 32'd0);
            end
            @(negedge clk);
        end
        idle();
        @(negedge clk);

        // ---- 4: writes of the magic word that must not halt.
        host_drive(1'b1, 1'b1, 8'd255, 32'h0000FE23, 4'hF);
        #1;
        check("t4_host_gnt", 32'(bus.host_gnt), 32'd1);
        check("t4_host_memwe", 32'(bus.mem_we), 32'hF);
        to_post_rise();
        check("t4_host_halt", 32'(bus.halt), 32'd0);
        @(negedge clk);
        idle();
        core_drive(1'b1, 1'b1, 8'd255, 32'h0000FE23, 4'h3);
        #1;
        check("t4_core_gnt", 32'(bus.core_gnt), 32'd1);
        to_post_rise();
        check("t4_partial_halt", 32'(bus.halt), 32'd0);
        @(negedge clk);
        core_drive(1'b1, 1'b0, 8'd255, 32'h0, 4'h0);
        to_post_rise();
        check("t4_readback", bus.core_rdata, 32'h0000FE23);
        @(negedge clk);

        // ---- 5: alternating core and host loads.
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i % 2 == 0) core_drive(1'b1, 1'b0, ADDR_W'(i), 32'h0, 4'h0);
            else            host_drive(1'b1, 1'b0, ADDR_W'(i), 32'h0, 4'h0);
            to_post_rise();
            check($sformatf("t5_core_rv%0d", i), 32'(bus.core_rvalid), (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t5_host_rv%0d", i), 32'(bus.host_rvalid), (i % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("t5_data%0d", i),
                  (i % 2 == 0) ? bus.core_rdata : bus.host_rdata, 32'hA5000000 + i);
            @(negedge clk);
        end
        idle();
        @(negedge clk);

        // ---- 3: halting store, then core locked out, host still served.
        core_drive(1'b1, 1'b1, 8'd255, 32'h0000FE23, 4'hF);
        #1;
        check("t3_gnt", 32'(bus.core_gnt), 32'd1);
        check("t3_halt_before", 32'(bus.halt), 32'd0);
        to_post_rise();
        check("t3_halt", 32'(bus.halt), 32'd1);
        @(negedge clk);
        core_drive(1'b1, 1'b0, 8'd0, 32'h0, 4'h0);
        #1;
        check("t3_stall", 32'(bus.core_stall), 32'd1);
        check("t3_core_gnt", 32'(bus.core_gnt), 32'd0);
        check("t3_mem_en", 32'(bus.mem_en), 32'd0);
        host_drive(1'b1, 1'b0, 8'd255, 32'h0, 4'h0);
        #1;
        check("t3_host_gnt", 32'(bus.host_gnt), 32'd1);
        to_post_rise();
        check("t3_host_rvalid", 32'(bus.host_rvalid), 32'd1);
        check("t3_host_rdata", bus.host_rdata, 32'h0000FE23);
        check("t3_halt_sticky", 32'(bus.halt), 32'd1);
        @(negedge clk);
        idle();

        // ---- 6: reset clears halt, outstanding read and host wait count.
        rst_n = 1'b1;
        #1;
        check("t6_halt_clr", 32'(bus.halt), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        core_drive(1'b1, 1'b0, 8'd3, 32'h0, 4'h0);
        host_drive(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("t6_pre_host_gnt%0d", k), 32'(bus.host_gnt), 32'd0);
            to_post_rise();
            if (k < 1) @(negedge clk);
        end
        check("t6_rv_before_rst", 32'(bus.core_rvalid), 32'd1);
        rst_n = 1'b1;
        #1;
        check("t6_rv_discard", 32'(bus.core_rvalid), 32'd0);
        check("t6_halt", 32'(bus.halt), 32'd0);
        @(negedge clk);
        #1;
        check("t6_rv_in_rst", 32'(bus.core_rvalid), 32'd0);
        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t6_host_gnt%0d", k), 32'(bus.host_gnt), (k == 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        idle();
        core_drive(1'b1, 1'b0, 8'd7, 32'h0, 4'h0);
        #1;
        check("t6_resume_gnt", 32'(bus.core_gnt), 32'd1);
        to_post_rise();
        check("t6_resume_rdata", bus.core_rdata, 32'hA5000007);
        check("t6_resume_rvalid", 32'(bus.core_rvalid), 32'd1);
        @(negedge clk);
        idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
